// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single-outstanding memory port.
// Data wins by default; a bounded starvation counter forces a fetch grant.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_size,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_err,
    output logic        mem_cs,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [2:0] SZ_BYTE  = 3'b000;
    localparam logic [2:0] SZ_HALF  = 3'b001;
    localparam logic [2:0] SZ_BYTEU = 3'b100;
    localparam logic [2:0] SZ_HALFU = 3'b101;

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] starve_cnt, starve_cnt_d;
    logic [1:0]    acc_lane, acc_lane_d;
    logic [2:0]    acc_size, acc_size_d;

    logic          mem_cs_d, if_done_d, dm_done_d, dm_err_d;
    logic [3:0]    mem_we_d;
    logic [31:0]   mem_addr_d, mem_wdata_d, if_rdata_d, dm_rdata_d;

    // Fetch addresses are word aligned; the low bits are intentionally ignored.
    logic unused_if_lo;
    assign unused_if_lo = ^if_addr[1:0];

    logic        is_byte, is_half, is_word, dm_misal, dm_pick;
    logic [3:0]  st_we;
    logic [31:0] st_wdata, ld_lane, ld_data;

    assign is_byte  = (dm_size == SZ_BYTE) || (dm_size == SZ_BYTEU);
    assign is_half  = (dm_size == SZ_HALF) || (dm_size == SZ_HALFU);
    assign is_word  = !is_byte && !is_half;
    assign dm_misal = (is_half && dm_addr[0]) || (is_word && (dm_addr[1:0] != 2'b00));
    assign dm_pick  = dm_req && ((starve_cnt < SMAX) || !if_req);

    always_comb begin
        st_we    = 4'b1111;
        st_wdata = dm_wdata;
        if (is_byte) begin
            st_we    = 4'b0001 << dm_addr[1:0];
            st_wdata = {4{dm_wdata[7:0]}};
        end else if (is_half) begin
            st_we    = dm_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{dm_wdata[15:0]}};
        end
    end

    assign ld_lane = mem_rdata >> {acc_lane, 3'b000};

    always_comb begin
        case (acc_size)
            SZ_BYTE:  ld_data = {{24{ld_lane[7]}}, ld_lane[7:0]};
            SZ_BYTEU: ld_data = {24'h0, ld_lane[7:0]};
            SZ_HALF:  ld_data = {{16{ld_lane[15]}}, ld_lane[15:0]};
            SZ_HALFU: ld_data = {16'h0, ld_lane[15:0]};
            default:  ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state;
        starve_cnt_d = starve_cnt;
        acc_lane_d   = acc_lane;
        acc_size_d   = acc_size;
        mem_cs_d     = mem_cs;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        if_rdata_d   = if_rdata;
        dm_rdata_d   = dm_rdata;
        if_done_d    = 1'b0;
        dm_done_d    = 1'b0;
        dm_err_d     = 1'b0;
        case (state)
            IDLE: begin
                if (dm_pick) begin
                    if (!if_req)
                        starve_cnt_d = '0;
                    else if (starve_cnt != SMAX)
                        starve_cnt_d = starve_cnt + 1'b1;
                    if (dm_misal) begin
                        state_d    = RESP;
                        dm_done_d  = 1'b1;
                        dm_err_d   = 1'b1;
                        dm_rdata_d = '0;
                    end else begin
                        state_d    = DM_ACC;
                        mem_cs_d   = 1'b1;
                        mem_we_d   = dm_we ? st_we : 4'b0000;
                        mem_addr_d = {dm_addr[31:2], 2'b00};
                        if (dm_we)
                            mem_wdata_d = st_wdata;
                        acc_lane_d = dm_addr[1:0];
                        acc_size_d = dm_size;
                    end
                end else if (if_req) begin
                    starve_cnt_d = '0;
                    state_d      = IF_ACC;
                    mem_cs_d     = 1'b1;
                    mem_we_d     = 4'b0000;
                    mem_addr_d   = {if_addr[31:2], 2'b00};
                end
            end
            IF_ACC: begin
                if (mem_ready) begin
                    state_d    = RESP;
                    mem_cs_d   = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            DM_ACC: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mem_cs_d  = 1'b0;
                    dm_done_d = 1'b1;
                    // Stores leave the load result bus untouched.
                    if (mem_we == 4'b0000)
                        dm_rdata_d = ld_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            acc_lane   <= 2'b00;
            acc_size   <= 3'b000;
            mem_cs     <= 1'b0;
            mem_we     <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            dm_err     <= 1'b0;
        end else begin
            state      <= state_d;
            starve_cnt <= starve_cnt_d;
            acc_lane   <= acc_lane_d;
            acc_size   <= acc_size_d;
            mem_cs     <= mem_cs_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            if_rdata   <= if_rdata_d;
            dm_rdata   <= dm_rdata_d;
            if_done    <= if_done_d;
            dm_done    <= dm_done_d;
            dm_err     <= dm_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/data arbitration, lane handling,
// misalignment, delayed ready, drop-before-done and mid-access reset.
module tb_mem_arbiter;

    localparam logic [2:0] BYTE  = 3'b000;
    localparam logic [2:0] HALF  = 3'b001;
    localparam logic [2:0] WORD  = 3'b010;
    localparam logic [2:0] BYTEU = 3'b100;
    localparam logic [2:0] HALFU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_done, dm_req, dm_we, dm_done, dm_err;
    logic        mem_cs, mem_ready;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [2:0]  dm_size;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_size(dm_size), .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One aligned data access with mem_ready high on the first mem_cs cycle.
    task automatic dm_op(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size,
                         input logic [31:0] rdata_in, input logic [3:0] exp_we,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata);
        dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_size = size;
        mem_rdata = rdata_in; mem_ready = 1'b1;
        tick;
        chk({tag, "_cs"}, mem_cs, 1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_we"}, mem_we, exp_we);
        if (we) chk({tag, "_wdata"}, mem_wdata, exp_wdata);
        tick;
        chk({tag, "_done"}, dm_done, 1);
        chk({tag, "_err"}, dm_err, 0);
        chk({tag, "_cs_drop"}, mem_cs, 0);
        if (!we) chk({tag, "_rdata"}, dm_rdata, exp_rdata);
        dm_req = 1'b0;
        tick;
    endtask

    initial begin
        bit   if_seen, both;
        int   n_dm, dm_before_if;

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0;
        dm_wdata = '0; dm_size = WORD; mem_rdata = '0; mem_ready = 1'b0;
        tick; tick;
        chk("rst_cs", mem_cs, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_dm_done", dm_done, 0);
        chk("rst_dm_err", dm_err, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        rst_n = 1'b1;

        // Basic fetch, minimum latency.
        if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h00500093;
        tick;
        chk("if_cs", mem_cs, 1);
        chk("if_addr", mem_addr, 32'h100);
        chk("if_we", mem_we, 0);
        chk("if_done_early", if_done, 0);
        tick;
        chk("if_done", if_done, 1);
        chk("if_rdata", if_rdata, 32'h00500093);
        chk("if_cs_drop", mem_cs, 0);
        if_req = 1'b0;
        tick;
        chk("if_done_pulse", if_done, 0);

        // Simultaneous requests: data first, then fetch.
        if_req = 1'b1; if_addr = 32'h303;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_size = WORD;
        mem_rdata = 32'h11223344;
        tick;
        chk("both_dm_first_addr", mem_addr, 32'h200);
        tick;
        chk("both_dm_done", dm_done, 1);
        chk("both_if_not_done", if_done, 0);
        chk("both_dm_rdata", dm_rdata, 32'h11223344);
        dm_req = 1'b0; mem_rdata = 32'hCAFEF00D;
        tick;
        chk("both_bubble_cs", mem_cs, 0);
        tick;
        chk("both_if_cs", mem_cs, 1);
        chk("both_if_addr", mem_addr, 32'h300);
        tick;
        chk("both_if_done", if_done, 1);
        chk("both_dm_quiet", dm_done, 0);
        chk("both_if_rdata", if_rdata, 32'hCAFEF00D);
        if_req = 1'b0;
        tick;

        // Starvation bound: four data grants, then the fetch.
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; dm_size = WORD;
        mem_rdata = 32'h5555AAAA;
        if_seen = 1'b0; both = 1'b0; n_dm = 0; dm_before_if = -1;
        for (int c = 0; c < 40 && !if_seen; c++) begin
            tick;
            if (dm_done && if_done) both = 1'b1;
            if (if_done) begin
                if_seen = 1'b1;
                dm_before_if = n_dm;
            end else if (dm_done) begin
                n_dm++;
            end
        end
        chk("starve_if_seen", 32'(if_seen), 1);
        chk("starve_dm_grants", 32'(dm_before_if), 4);
        chk("starve_no_overlap", 32'(both), 0);
        if_req = 1'b0; dm_req = 1'b0;
        tick;

        // Lane handling for stores and loads.
        dm_op("st_byte", 1'b1, 32'h203, 32'h123456AB, BYTE, 32'h0, 4'b1000,
              32'h200, 32'hABABABAB, 32'h0);
        dm_op("st_half", 1'b1, 32'h202, 32'h1234BEEF, HALF, 32'h0, 4'b1100,
              32'h200, 32'hBEEFBEEF, 32'h0);
        dm_op("st_halfu_lo", 1'b1, 32'h010, 32'h00007777, HALFU, 32'h0, 4'b0011,
              32'h010, 32'h77777777, 32'h0);
        dm_op("st_word", 1'b1, 32'h020, 32'hA5A5F00F, WORD, 32'h0, 4'b1111,
              32'h020, 32'hA5A5F00F, 32'h0);
        dm_op("ld_byte", 1'b0, 32'h203, 32'h0, BYTE, 32'h80123456, 4'b0000,
              32'h200, 32'h0, 32'hFFFFFF80);
        dm_op("ld_byteu", 1'b0, 32'h203, 32'h0, BYTEU, 32'h80123456, 4'b0000,
              32'h200, 32'h0, 32'h00000080);
        dm_op("ld_byte_l1", 1'b0, 32'h201, 32'h0, BYTE, 32'h80123456, 4'b0000,
              32'h200, 32'h0, 32'h00000034);
        dm_op("ld_half_hi", 1'b0, 32'h202, 32'h0, HALF, 32'h8001FFFF, 4'b0000,
              32'h200, 32'h0, 32'hFFFF8001);
        dm_op("ld_halfu_lo", 1'b0, 32'h000, 32'h0, HALFU, 32'h1234F00F, 4'b0000,
              32'h000, 32'h0, 32'h0000F00F);
        dm_op("ld_undef_sz", 1'b0, 32'h040, 32'h0, 3'b111, 32'h87654321, 4'b0000,
              32'h040, 32'h0, 32'h87654321);
        chk("wdata_hold", mem_wdata, 32'hA5A5F00F);

        // Misaligned word load.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h202; dm_size = WORD;
        tick;
        chk("mis_cs", mem_cs, 0);
        chk("mis_done", dm_done, 1);
        chk("mis_err", dm_err, 1);
        chk("mis_rdata", dm_rdata, 0);
        dm_req = 1'b0;
        tick;
        chk("mis_err_pulse", dm_err, 0);
        chk("mis_done_pulse", dm_done, 0);

        // Requester drops before a delayed ready; access still completes.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h044; dm_size = WORD;
        mem_ready = 1'b0; mem_rdata = 32'h0000ABCD;
        tick;
        chk("drop_cs", mem_cs, 1);
        dm_req = 1'b0;
        tick; tick;
        chk("drop_cs_held", mem_cs, 1);
        chk("drop_no_done", dm_done, 0);
        mem_ready = 1'b1;
        tick;
        chk("drop_done", dm_done, 1);
        chk("drop_rdata", dm_rdata, 32'h0000ABCD);
        tick;

        // Delayed ready, then asynchronous reset mid-access.
        if_req = 1'b1; if_addr = 32'h700; mem_ready = 1'b0;
        tick;
        chk("rst_acc_cs", mem_cs, 1);
        for (int c = 0; c < 5; c++) tick;
        chk("rst_acc_wait_cs", mem_cs, 1);
        chk("rst_acc_wait_addr", mem_addr, 32'h700);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_cs", mem_cs, 0);
        @(posedge clk); #1;
        chk("rst_no_done", if_done, 0);
        rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick;
        chk("rst_regrant_cs", mem_cs, 1);
        chk("rst_regrant_addr", mem_addr, 32'h700);
        tick;
        chk("rst_regrant_done", if_done, 1);
        chk("rst_regrant_rdata", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
